// File: rtl/imm_extend_unit.sv
// imm_extend_unit: immediate zero/sign/upper/branch extension into a 2-entry skid queue
module imm_extend_unit #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32,
    parameter int TAG_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_mode,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic [1:0]           count
);
    localparam int E = OUT_WIDTH - IN_WIDTH;

    generate
        if (IN_WIDTH < 2 || OUT_WIDTH < IN_WIDTH + 2) begin : g_bad_width
            $error("imm_extend_unit: need IN_WIDTH >= 2 and OUT_WIDTH >= IN_WIDTH+2");
        end
    endgenerate

    logic [OUT_WIDTH-1:0] zx, sx, ext_data, head_data, tail_data;
    logic [TAG_WIDTH-1:0] head_tag, tail_tag;
    logic [1:0]           count_n;
    logic                 push, pop;

    always_comb begin
        zx       = {{E{1'b0}}, in_data};
        sx       = {{E{in_data[IN_WIDTH-1]}}, in_data};
        ext_data = in_mode == 2'd0 ? zx :
                   in_mode == 2'd1 ? sx :
                   in_mode == 2'd2 ? {in_data, {E{1'b0}}} :
                                     {sx[OUT_WIDTH-3:0], 2'b00};
        push     = in_valid & in_ready;
        pop      = out_valid & out_ready;
        count_n  = count + {1'b0, push} - {1'b0, pop};
    end

    assign out_valid = count != 2'd0;
    assign out_data  = head_data;
    assign out_tag   = head_tag;

    // in_ready tracks the next occupancy so it is a pure register output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= 2'd0;
            in_ready  <= 1'b1;
            head_data <= '0;
            head_tag  <= '0;
            tail_data <= '0;
            tail_tag  <= '0;
        end else begin
            count    <= count_n;
            in_ready <= count_n != 2'd2;
            if (pop && count == 2'd2) begin
                head_data <= tail_data;
                head_tag  <= tail_tag;
            end
            if (push && (count == 2'd0 || pop)) begin
                head_data <= ext_data;
                head_tag  <= in_tag;
            end
            if (push && count == 2'd1 && !pop) begin
                tail_data <= ext_data;
                tail_tag  <= in_tag;
            end
        end
    end
endmodule

// File: tb/tb_imm_extend_unit.sv
// tb_imm_extend_unit: vector tables, corner sequences and a scoreboard soak for imm_extend_unit
module tb_imm_extend_unit;
    logic        clk = 0, rst_n = 0;
    logic        in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid;
    logic [1:0]  in_mode = 0, count;
    logic [15:0] in_data = 0;
    logic [4:0]  in_tag = 0, out_tag;
    logic [31:0] out_data;

    logic        s_in_valid = 0, s_in_ready, s_out_valid;
    logic [1:0]  s_in_mode = 0, s_count;
    logic [7:0]  s_in_data = 0;
    logic [4:0]  s_in_tag = 0, s_out_tag;
    logic [15:0] s_out_data;

    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    imm_extend_unit dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .count(count)
    );

    imm_extend_unit #(.IN_WIDTH(8), .OUT_WIDTH(16), .TAG_WIDTH(5)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_mode(s_in_mode), .in_data(s_in_data), .in_tag(s_in_tag),
        .out_valid(s_out_valid), .out_ready(1'b1), .out_data(s_out_data),
        .out_tag(s_out_tag), .count(s_count)
    );

    typedef struct { logic [15:0] d; logic [1:0] m; logic [31:0] e; } vec_t;
    typedef struct { logic [7:0] d; logic [1:0] m; logic [15:0] e; } vec8_t;
    typedef struct { logic [31:0] d; logic [4:0] t; } ent_t;

    vec_t  tv[5];
    vec8_t tv8[3];
    ent_t  q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Extension from its arithmetic meaning: value as unsigned or two's complement, scaled, taken mod 2^ow
    function automatic logic [63:0] ext(input logic [63:0] d, input int m, input int iw, input int ow);
        longint v = longint'(d);
        if ((m == 1 || m == 3) && d[iw-1]) v = v - (longint'(1) << iw);
        if (m == 2) v = v * (longint'(1) << (ow - iw));
        if (m == 3) v = v * 4;
        return 64'(v) & ((64'd1 << ow) - 64'd1);
    endfunction

    initial begin
        logic       pushed, popped, held;
        logic [31:0] hold_d;
        logic [4:0]  hold_t;
        tv[0]  = '{16'h8001, 2'd0, 32'h00008001};
        tv[1]  = '{16'h8001, 2'd1, 32'hFFFF8001};
        tv[2]  = '{16'h1234, 2'd2, 32'h12340000};
        tv[3]  = '{16'hFFFF, 2'd3, 32'hFFFFFFFC};
        tv[4]  = '{16'h4000, 2'd3, 32'h00010000};
        tv8[0] = '{8'h80, 2'd1, 16'hFF80};
        tv8[1] = '{8'h80, 2'd2, 16'h8000};
        tv8[2] = '{8'hC0, 2'd3, 16'hFF00};

        step; step;
        chk("rst_count", 64'(count), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_out_data", 64'(out_data), 0);
        chk("rst_out_tag", 64'(out_tag), 0);
        rst_n = 1;
        step;

        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1; in_data = tv[i].d; in_mode = tv[i].m; in_tag = 5'(i);
            step;
            chk("mode_valid", 64'(out_valid), 1);
            chk("mode_data", 64'(out_data), 64'(tv[i].e));
            chk("mode_model", 64'(out_data), ext(64'(tv[i].d), int'(tv[i].m), 16, 32));
            in_valid = 0;
        end
        step;
        chk("drain_count", 64'(count), 0);

        for (int i = 0; i < 3; i++) begin
            s_in_valid = 1; s_in_data = tv8[i].d; s_in_mode = tv8[i].m;
            step;
            chk("w8_valid", 64'(s_out_valid), 1);
            chk("w8_data", 64'(s_out_data), 64'(tv8[i].e));
            s_in_valid = 0;
        end
        step;

        out_ready = 0; in_valid = 1; in_mode = 0;
        in_tag = 1; in_data = 1; step;
        chk("bp_count1", 64'(count), 1);
        in_tag = 2; in_data = 2; step;
        chk("bp_count2", 64'(count), 2);
        chk("bp_in_ready", 64'(in_ready), 0);
        in_tag = 3; in_data = 3; step;
        chk("bp_hold_count", 64'(count), 2);
        chk("bp_head_tag", 64'(out_tag), 1);
        out_ready = 1; step;
        chk("bp_pop1_tag", 64'(out_tag), 2);
        chk("bp_pop1_ready", 64'(in_ready), 1);
        step;
        chk("bp_pop2_tag", 64'(out_tag), 3);
        chk("bp_pop2_data", 64'(out_data), 3);
        in_valid = 0; step;
        chk("bp_empty", 64'(count), 0);

        for (int i = 10; i < 14; i++) begin
            in_valid = 1; in_tag = 5'(i); in_data = 16'(i);
            step;
            chk("pp_count", 64'(count), 1);
            chk("pp_tag", 64'(out_tag), 64'(i));
        end
        in_valid = 0; step;

        out_ready = 0; in_valid = 1; in_mode = 2; in_data = 16'hABCD;
        step; step;
        chk("ar_pre_count", 64'(count), 2);
        in_valid = 0;
        #3 rst_n = 0;
        #1;
        chk("ar_out_valid", 64'(out_valid), 0);
        chk("ar_count", 64'(count), 0);
        chk("ar_in_ready", 64'(in_ready), 1);
        #2 rst_n = 1;
        out_ready = 1; in_valid = 1; in_mode = 1; in_data = 16'h0001; in_tag = 7;
        step;
        chk("ar_first_data", 64'(out_data), 64'h00000001);
        chk("ar_first_tag", 64'(out_tag), 7);
        in_valid = 0; step;

        q = {};
        for (int c = 0; c < 10000; c++) begin
            if (!(in_valid && !in_ready)) begin
                in_valid = 1'($urandom_range(1));
                in_mode = 2'($urandom_range(3));
                in_data = 16'($urandom);
                in_tag = 5'($urandom);
            end
            out_ready = 1'($urandom_range(1));
            #1;
            chk("sk_count", 64'(count), 64'(q.size()));
            chk("sk_in_ready", 64'(in_ready), 64'(q.size() != 2));
            pushed = in_valid && in_ready;
            popped = out_valid && out_ready;
            held = out_valid && !out_ready;
            hold_d = out_data; hold_t = out_tag;
            if (popped && q.size() > 0) begin
                chk("sk_data", 64'(out_data), 64'(q[0].d));
                chk("sk_tag", 64'(out_tag), 64'(q[0].t));
                void'(q.pop_front());
            end
            if (pushed) q.push_back('{32'(ext(64'(in_data), int'(in_mode), 16, 32)), in_tag});
            step;
            if (held) begin
                chk("sk_stable_data", 64'(out_data), 64'(hold_d));
                chk("sk_stable_tag", 64'(out_tag), 64'(hold_t));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/imm_extend_unit.md
# imm_extend_unit

Parametrised, handshaked immediate-extension unit for the MIPS core datapath. It converts an IN_WIDTH immediate into an OUT_WIDTH operand in one of four modes: zero-extend, sign-extend, upper-load or branch-offset. The result is buffered in a 2-entry skid queue, so the decode stage and the execute stage can stall independently. It sits between instruction decode and the ALU/branch-target operand mux.

## Interface
- IN_WIDTH, 16, immediate width; must be ≥ 2.
- OUT_WIDTH, 32, operand width; OUT_WIDTH ≥ IN_WIDTH+2, otherwise elaboration fails.
- TAG_WIDTH, 5, sideband tag (e.g. destination register) carried alongside the data.

- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  producer offers an immediate.
- in_ready  output  1  unit can accept; registered, equals (count != 2).
- in_mode  input  2  0 = zero-ext, 1 = sign-ext, 2 = upper, 3 = branch-offset.
- in_data  input  IN_WIDTH  raw immediate.
- in_tag  input  TAG_WIDTH  sideband, passed through unchanged.
- out_valid  output  1  head entry present; equals (count != 0).
- out_ready  input  1  consumer takes the head this cycle.
- out_data  output  OUT_WIDTH  extended operand of the head entry.
- out_tag  output  TAG_WIDTH  tag of the head entry.
- count  output  2  occupancy, 0..2.

## Operation
- Conversion is combinational on the input side; the converted value is stored in the queue. Let E = OUT_WIDTH-IN_WIDTH.
  - Mode 0: {E zeros, in_data}.
  - Mode 1: {E copies of in_data[IN_WIDTH-1], in_data}.
  - Mode 2: {in_data, E zeros}, i.e. an LUI-style shift by E.
  - Mode 3: the mode-1 result shifted left by 2; the top 2 bits are discarded and the low 2 bits are 0.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Queue states:
  - EMPTY (count 0):
    - push → ONE, head = new entry.
  - ONE (count 1):
    - push only → TWO, tail = new entry.
    - pop only → EMPTY.
    - push & pop → stays ONE, head = new entry.
    - neither → stays ONE.
  - TWO (count 2):
    - in_ready = 0, so no push occurs.
    - pop → ONE, head = previous tail.
    - otherwise holds.
- out_data and out_tag always reflect the head entry. They hold stable while out_valid=1 and out_ready=0.
- in_valid while in_ready=0: no state change. The producer must hold its inputs.
- An X or illegal mode value cannot occur; all four encodings are defined.

## Timing
- Reset (rst_n low, asynchronous) values:
  - count = 0.
  - out_valid = 0.
  - in_ready = 1.
  - out_data = 0.
  - out_tag = 0.
- Reset mid-operation discards all entries immediately, without waiting for a clock edge.
- Latency: an entry pushed at edge N is visible on out_data with out_valid=1 after edge N (in cycle N+1), provided the queue was empty or the previous head was popped at edge N.
- Throughput: one entry per cycle with out_ready held high. count then stays at 1 after the first push.
- in_ready is registered: it drops in the cycle after the queue reaches TWO. The second slot absorbs the one in-flight entry, so no combinational path exists from out_ready to in_ready.
- No combinational path exists from in_* to out_*.

## Test plan
- Mode sweep, OUT_WIDTH=32, IN_WIDTH=16, out_ready=1:
  - 0x8001 mode0 → 0x00008001.
  - 0x8001 mode1 → 0xFFFF8001.
  - 0x1234 mode2 → 0x12340000.
  - 0xFFFF mode3 → 0xFFFFFFFC.
  - 0x4000 mode3 → 0x00010000.
  - Each result appears one cycle after acceptance.
- Backpressure: out_ready=0, push tags 1, 2, 3 on consecutive cycles.
  - count goes 1, then 2.
  - in_ready drops after the second push, so tag 3 is held.
  - out_ready=1 → tags emerge in order 1, 2, 3 with no loss or duplication.
- Simultaneous push/pop in ONE: count stays 1 and out_tag updates each cycle.
- Async reset with count=2: assert rst_n low mid-cycle.
  - out_valid=0, count=0 and in_ready=1 take effect immediately.
  - After release, the first push of 0x0001 mode1 → 0x00000001.
- Parameter case IN_WIDTH=8, OUT_WIDTH=16:
  - 0x80 mode1 → 0xFF80.
  - 0x80 mode2 → 0x8000.
  - 0xC0 mode3 → 0xFF00.
- Random valid/ready soak (10k cycles) against a scoreboard:
  - Order and data are preserved.
  - out_data never changes while out_valid=1 and out_ready=0.
